// File: rtl/mips_pipeline_core.sv
// mips_pipeline_core: 5-stage 16-bit-ISA MIPS pipeline (clk, reset active-low sync; imem_* fetch, dmem_* load/store, retire, halted)
module mips_pipeline_core #(
  parameter int DATA_W = 16,
  parameter bit FWD_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  output logic [15:0]       imem_addr,
  input  logic [15:0]       imem_data,
  output logic [15:0]       dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_we,
  output logic              dmem_re,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              retire,
  output logic              halted
);
  typedef struct packed {
    logic        v;
    logic [15:0] pc;
    logic [15:0] ins;
  } ifid_t;
  typedef struct packed {
    logic              v;
    logic [15:0]       pc;
    logic [3:0]        op, rs, rt, dst;
    logic [DATA_W-1:0] a, b, imm;
    logic              wreg, mw, mr, bne, halt;
  } idex_t;
  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] res, wd;
    logic [3:0]        dst;
    logic              wreg, mw, mr, halt;
  } exmem_t;
  typedef struct packed {
    logic              v;
    logic [DATA_W-1:0] res;
    logic [3:0]        dst;
    logic              wreg, halt;
  } memwb_t;
  logic [15:0]       pc;
  logic              halting;
  ifid_t             ifid;
  idex_t             idex, idex_n;
  exmem_t            exmem;
  memwb_t            memwb;
  logic [DATA_W-1:0] rf [16];
  logic [3:0]        op, rs, rt;
  logic              rtype, use_rs, use_rt, id_wreg, id_halt, id_jmp;
  logic              wb_we, ex_hit, mem_hit, stall;
  logic              fwd_m, fwd_w, slt, taken;
  logic [15:0]       pc1, jt, target;
  logic [DATA_W-1:0] fa, fb, alu;
  assign op      = ifid.ins[15:12];
  assign rs      = ifid.ins[11:8];
  assign rt      = ifid.ins[7:4];
  assign rtype   = op < 4'd5;
  assign use_rs  = op <= 4'd8;
  assign use_rt  = rtype | op == 4'd7 | op == 4'd8;
  assign id_wreg = rtype | op == 4'd5 | op == 4'd6;
  assign id_halt = ifid.v & op == 4'hF;
  assign id_jmp  = ifid.v & op == 4'd9;
  assign pc1     = ifid.pc + 16'd1;
  assign jt      = {pc1[15:12], ifid.ins[11:0]};
  assign wb_we   = memwb.v & memwb.wreg & |memwb.dst;
  assign ex_hit  = idex.v & idex.wreg & |idex.dst &
                   ((use_rs & rs == idex.dst) | (use_rt & rt == idex.dst));
  assign mem_hit = exmem.v & exmem.wreg & |exmem.dst &
                   ((use_rs & rs == exmem.dst) | (use_rt & rt == exmem.dst));
  // With forwarding only a load one stage ahead is too late; without it, wait until the producer reaches WB
  assign stall   = ifid.v & (FWD_EN ? ex_hit & idex.mr : ex_hit | mem_hit);
  always_comb begin
    idex_n      = '0;
    idex_n.v    = ifid.v;
    idex_n.pc   = ifid.pc;
    idex_n.op   = op;
    idex_n.rs   = rs;
    idex_n.rt   = rt;
    idex_n.dst  = rtype ? ifid.ins[3:0] : rt;
    idex_n.a    = wb_we && memwb.dst == rs ? memwb.res : rf[rs];
    idex_n.b    = wb_we && memwb.dst == rt ? memwb.res : rf[rt];
    idex_n.imm  = {{(DATA_W-4){ifid.ins[3]}}, ifid.ins[3:0]};
    idex_n.wreg = ifid.v & id_wreg;
    idex_n.mw   = ifid.v & op == 4'd7;
    idex_n.mr   = ifid.v & op == 4'd6;
    idex_n.bne  = ifid.v & op == 4'd8;
    idex_n.halt = id_halt;
  end
  assign fwd_m  = FWD_EN & exmem.v & exmem.wreg & |exmem.dst;
  assign fwd_w  = FWD_EN & wb_we;
  assign fa     = fwd_m && exmem.dst == idex.rs ? exmem.res :
                  fwd_w && memwb.dst == idex.rs ? memwb.res : idex.a;
  assign fb     = fwd_m && exmem.dst == idex.rt ? exmem.res :
                  fwd_w && memwb.dst == idex.rt ? memwb.res : idex.b;
  assign slt    = $signed(fa) < $signed(fb);
  assign alu    = idex.op == 4'd0 ? fa + fb :
                  idex.op == 4'd1 ? fa - fb :
                  idex.op == 4'd2 ? fa & fb :
                  idex.op == 4'd3 ? fa | fb :
                  idex.op == 4'd4 ? {{(DATA_W-1){1'b0}}, slt} : fa + idex.imm;
  assign taken  = idex.v & idex.bne & (fa != fb);
  assign target = idex.pc + 16'd1 + idex.imm[15:0];
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc      <= '0;
      ifid    <= '0;
      idex    <= '0;
      exmem   <= '0;
      memwb   <= '0;
      halting <= 1'b0;
      halted  <= 1'b0;
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else begin
      exmem  <= '{v: idex.v, res: alu, wd: fb, dst: idex.dst, wreg: idex.wreg,
                  mw: idex.mw, mr: idex.mr, halt: idex.halt};
      memwb  <= '{v: exmem.v, res: exmem.mr ? dmem_rdata : exmem.res, dst: exmem.dst,
                  wreg: exmem.wreg, halt: exmem.halt};
      if (wb_we) rf[memwb.dst] <= memwb.res;
      halted <= halted | (memwb.v & memwb.halt);
      if (taken) begin
        pc   <= target;
        ifid <= '0;
        idex <= '0;
      end else if (stall) begin
        idex <= '0;
      end else begin
        idex <= idex_n;
        if (halting | id_halt) begin
          ifid    <= '0;
          halting <= 1'b1;
        end else if (id_jmp) begin
          pc   <= jt;
          ifid <= '0;
        end else begin
          pc   <= pc + 16'd1;
          ifid <= '{v: 1'b1, pc: pc, ins: imem_data};
        end
      end
    end
  end
  assign imem_addr  = pc;
  assign dmem_addr  = exmem.res[15:0];
  assign dmem_wdata = exmem.wd;
  // Gated by reset so a store sitting in MEM never lands while reset is being applied
  assign dmem_we    = reset & exmem.v & exmem.mw;
  assign dmem_re    = reset & exmem.v & exmem.mr;
  assign retire     = memwb.v;
endmodule

// File: tb/tb_mips_pipeline_core.sv
// tb_mips_pipeline_core: directed checks of three core configurations sharing one instruction memory
module tb_mips_pipeline_core;
  logic        clk, reset;
  logic [15:0] im [256];
  logic [15:0] ia [3];
  logic [15:0] da [3];
  logic [2:0]  we, re, ret, hl;
  logic [15:0] wd0, wd1;
  logic [31:0] wd2;
  logic [31:0] wd [3];
  logic [31:0] dm [3][16];
  int          nst [3], fs [3], rc [3], nl [3];
  int          cyc, nchk, nerr;
  logic [15:0] rd0, rd1;
  logic [31:0] rd2;
  assign wd[0] = {16'b0, wd0};
  assign wd[1] = {16'b0, wd1};
  assign wd[2] = wd2;
  assign rd0 = dm[0][da[0][3:0]][15:0];
  assign rd1 = dm[1][da[1][3:0]][15:0];
  assign rd2 = dm[2][da[2][3:0]];
  mips_pipeline_core #(.DATA_W(16), .FWD_EN(1)) u0 (
    .clk(clk), .reset(reset), .imem_addr(ia[0]), .imem_data(im[ia[0][7:0]]),
    .dmem_addr(da[0]), .dmem_wdata(wd0), .dmem_we(we[0]), .dmem_re(re[0]),
    .dmem_rdata(rd0), .retire(ret[0]), .halted(hl[0]));
  mips_pipeline_core #(.DATA_W(16), .FWD_EN(0)) u1 (
    .clk(clk), .reset(reset), .imem_addr(ia[1]), .imem_data(im[ia[1][7:0]]),
    .dmem_addr(da[1]), .dmem_wdata(wd1), .dmem_we(we[1]), .dmem_re(re[1]),
    .dmem_rdata(rd1), .retire(ret[1]), .halted(hl[1]));
  mips_pipeline_core #(.DATA_W(32), .FWD_EN(1)) u2 (
    .clk(clk), .reset(reset), .imem_addr(ia[2]), .imem_data(im[ia[2][7:0]]),
    .dmem_addr(da[2]), .dmem_wdata(wd2), .dmem_we(we[2]), .dmem_re(re[2]),
    .dmem_rdata(rd2), .retire(ret[2]), .halted(hl[2]));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (!reset) begin
      cyc <= 0;
      for (int d = 0; d < 3; d++) begin
        for (int i = 0; i < 16; i++) dm[d][i] <= (i == 3) ? 32'd7 : 32'd0;
        nst[d] <= 0;
        fs[d]  <= 0;
        rc[d]  <= 0;
        nl[d]  <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      for (int d = 0; d < 3; d++) begin
        if (we[d]) begin
          dm[d][da[d][3:0]] <= wd[d];
          nst[d] <= nst[d] + 1;
          if (nst[d] == 0) fs[d] <= cyc + 1;
        end
        if (re[d]) nl[d] <= nl[d] + 1;
        if (ret[d]) rc[d] <= rc[d] + 1;
      end
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic clear_prog();
    foreach (im[i]) im[i] = 16'hA000;
  endtask
  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pc", {16'b0, ia[0]}, 32'd0);
    check("rst_halted", {29'b0, hl}, 32'd0);
    reset = 1'b1;
  endtask
  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    nchk = 0;
    nerr = 0;
    reset = 1'b0;
    clear_prog();
    im[0] = 16'h5015;
    im[1] = 16'h0112;
    im[2] = 16'h7020;
    im[3] = 16'hF000;
    @(negedge clk);
    apply_reset();
    check("rst_we", {29'b0, we}, 32'd0);
    check("rst_retire", {29'b0, ret}, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("pc_seq", {16'b0, ia[0]}, k);
    end
    run(22);
    check("fwd_edge", fs[0], 6);
    check("fwd_data", dm[0][0], 32'd10);
    check("nofwd_edge", fs[1], 10);
    check("nofwd_data", dm[1][0], 32'd10);
    check("fwd_halted", {31'b0, hl[0]}, 32'd1);
    check("fwd_retire", rc[0], 4);
    clear_prog();
    im[0] = 16'h5053;
    im[1] = 16'h6530;
    im[2] = 16'h0334;
    im[3] = 16'h7041;
    im[4] = 16'hF000;
    apply_reset();
    run(20);
    check("lu_edge", fs[0], 8);
    check("lu_data", dm[0][1], 32'd14);
    check("lu_loads", nl[0], 1);
    check("lu_stores", nst[0], 1);
    check("lu_nofwd_data", dm[1][1], 32'd14);
    clear_prog();
    im[0] = 16'h5011;
    im[1] = 16'h8102;
    im[2] = 16'h7012;
    im[3] = 16'h7013;
    im[4] = 16'h7014;
    im[5] = 16'hF000;
    apply_reset();
    run(20);
    check("bt_stores", nst[0], 1);
    check("bt_m2", dm[0][2], 32'd0);
    check("bt_m3", dm[0][3], 32'd7);
    check("bt_m4", dm[0][4], 32'd1);
    im[1] = 16'h8002;
    apply_reset();
    run(20);
    check("bn_stores", nst[0], 3);
    check("bn_m2", dm[0][2], 32'd1);
    check("bn_m3", dm[0][3], 32'd1);
    check("bn_m4", dm[0][4], 32'd1);
    clear_prog();
    im[0]  = 16'h9010;
    im[1]  = 16'h7005;
    im[16] = 16'hF000;
    apply_reset();
    run(12);
    check("jh_retire", rc[0], 2);
    check("jh_halted", {31'b0, hl[0]}, 32'd1);
    check("jh_stores", nst[0], 0);
    check("jh_pc", {16'b0, ia[0]}, 32'h11);
    run(5);
    check("jh_pc_frozen", {16'b0, ia[0]}, 32'h11);
    check("jh_retire_frozen", rc[0], 2);
    clear_prog();
    im[0] = 16'h501F;
    im[1] = 16'h4102;
    im[2] = 16'h7010;
    im[3] = 16'h7021;
    im[4] = 16'h5003;
    im[5] = 16'h7002;
    im[6] = 16'hF000;
    apply_reset();
    run(20);
    check("w32_neg1", dm[2][0], 32'hFFFF_FFFF);
    check("w32_slt", dm[2][1], 32'd1);
    check("w32_r0", dm[2][2], 32'd0);
    check("w32_stores", nst[2], 3);
    check("w16_neg1", dm[0][0], 32'h0000_FFFF);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
